// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Iteration counter width; a one-bit counter still works when N is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/seq_divider_if.sv
// Controller-facing start/busy/done handshake and operand/result bus of seq_divider.
interface seq_divider_if #(
  parameter int N = seq_divider_pkg::DEF_N
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left by one, then try R - D.
module div_step #(
  parameter int N = seq_divider_pkg::DEF_N
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);

  localparam logic [N:0] ONE_W = (N+1)'(1);

  logic [N+1:0] shifted;
  logic [N:0]   r_sh;
  logic [N:0]   trial;

  always_comb begin
    // NOTE: every output gets a default before the conditional update, so no latch is inferred.
    shifted = {r, q[N-1]};
    r_sh    = shifted[N:0];
    q_next  = q << 1;
    trial   = r_sh + ~{1'b0, d} + ONE_W;
    r_next  = r_sh;
    if (!trial[N]) begin
      r_next    = trial;
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t         state, state_n;
  logic [N:0]     r, r_next;
  logic [N-1:0]   q, q_next, d;
  logic [CW-1:0]  cnt;
  logic           accept, zero_div, last;
  logic [N-1:0]   dvd_mag, dvs_mag, q_res, r_res;
  logic [N-1:0]   quotient_q, remainder_q;
  logic           div_zero_q;

  assign accept   = bus.start && (state != RUN);
  assign zero_div = (bus.divisor == '0);
  assign last     = (state == RUN) && (cnt == '0);

  div_step #(.N(N)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [N-1:0] ONE_N = N'(1);

  logic neg_q, neg_r;

  // Magnitudes go in, signs are restored on the final iteration's results.
  always_comb begin
    dvd_mag = bus.dividend[N-1] ? (~bus.dividend + ONE_N) : bus.dividend;
    dvs_mag = bus.divisor[N-1]  ? (~bus.divisor  + ONE_N) : bus.divisor;
    q_res   = neg_q ? (~q_next + ONE_N) : q_next;
    r_res   = neg_r ? (~r_next[N-1:0] + ONE_N) : r_next[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
      neg_r <= bus.dividend[N-1];
    end
  end
`else
  always_comb begin
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
    q_res   = q_next;
    r_res   = r_next[N-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always updated with non-blocking assignments.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start)           state_n = zero_div ? DONE : RUN;
        else if (state == DONE)  state_n = IDLE;
      end
      RUN:     if (cnt == '0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: working registers are reset as well as the outputs, so an aborted operation leaves nothing behind.
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      r   <= '0;
      q   <= dvd_mag;
      d   <= dvs_mag;
      cnt <= CNT_INIT;
      if (zero_div) begin
        quotient_q  <= '1;
        remainder_q <= bus.dividend;
        div_zero_q  <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_next;
      q   <= q_next;
      cnt <= cnt - CNT_ONE;
      if (last) begin
        quotient_q  <= q_res;
        remainder_q <= r_res;
        div_zero_q  <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (N=4); adds signed cases when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] held_q = '0;
  logic [N-1:0] held_r = '0;
  logic         held_dz = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   qi, ri;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q = qi[N-1:0];
      e.r = ri[N-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to done; inject_at > 0 pulses a foreign start in that cycle.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int inject_at);
    exp_t e, got;
    int   lat;
    int   k;
    logic seen;
    sb.push_back(model(a, b));
    lat = (b == '0) ? 1 : N + 1;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    step();
    bus.start = 1'b0;
    bus.dividend = ~a;
    bus.divisor = '0;
    seen = 1'b0;
    k = 1;
    while (k <= N + 4 && !seen) begin
      if (k > 1) step();
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        check("latency", k, lat);
        check("busy_at_done", bus.busy, 1'b0);
        if (sb.size() == 0) begin
          check("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          got.q = bus.quotient;
          got.r = bus.remainder;
          got.dz = bus.div_zero;
          check("quotient", got.q, e.q);
          check("remainder", got.r, e.r);
          check("div_zero", got.dz, e.dz);
          held_q = e.q;
          held_r = e.r;
          held_dz = e.dz;
        end
      end else begin
        check("busy", bus.busy, (b != '0) && (k <= N));
        check("hold_quotient", bus.quotient, held_q);
        check("hold_remainder", bus.remainder, held_r);
        check("hold_div_zero", bus.div_zero, held_dz);
        if (k == inject_at) begin
          bus.start = 1'b1;
          bus.dividend = a ^ 4'h5;
          bus.divisor = 4'h1;
        end else begin
          bus.start = 1'b0;
        end
      end
      k++;
    end
    bus.start = 1'b0;
    check("done_seen", seen, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_done", bus.done, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_quotient", bus.quotient, held_q);
      check("idle_remainder", bus.remainder, held_r);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12 rst_n = 1'b1;
    step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_div_zero", bus.div_zero, 1'b0);

    do_op(4'd13, 4'd3, 0);
    idle(1);
    do_op(4'd7, 4'd0, 0);
    idle(1);
    do_op(4'd15, 4'd1, 0);
    do_op(4'd2, 4'd9, 0);
    idle(2);
    do_op(4'd13, 4'd3, 2);
    idle(1);

    // Reset in the middle of an operation discards it and clears outputs at once.
    bus.start = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_quotient", bus.quotient, 0);
    check("arst_remainder", bus.remainder, 0);
    check("arst_div_zero", bus.div_zero, 1'b0);
    held_q = '0;
    held_r = '0;
    held_dz = 1'b0;
    step();
    rst_n = 1'b1;
    idle(1);
    do_op(4'd9, 4'd2, 0);
    idle(1);

    for (int i = 0; i < 6; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
      idle(1);
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op(4'h9, 4'h2, 0);
    idle(1);
    do_op(4'h8, 4'hF, 0);
    idle(1);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
